// File: rtl/gray_pkg.sv
// Shared definitions for the gray counter checker: width, code points,
// FSM encoding and error cause bits.
package gray_pkg;

  localparam int GRAY_W = 3;

  localparam logic [GRAY_W-1:0] G0 = 3'b000;
  localparam logic [GRAY_W-1:0] G1 = 3'b001;
  localparam logic [GRAY_W-1:0] G2 = 3'b011;
  localparam logic [GRAY_W-1:0] G3 = 3'b010;
  localparam logic [GRAY_W-1:0] G4 = 3'b110;
  localparam logic [GRAY_W-1:0] G5 = 3'b111;
  localparam logic [GRAY_W-1:0] G6 = 3'b101;
  localparam logic [GRAY_W-1:0] G7 = 3'b100;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_ERR   = 2'd2;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_STEP = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_checker_if.sv
// Signals between the upstream gray counter, its enable/clear source and
// the checker.
interface gray_checker_if;
  import gray_pkg::*;

  logic              En;
  logic [GRAY_W-1:0] Gray;
  logic              Overflow;
  logic              Clear;
  logic [GRAY_W-1:0] Bin;
  logic [7:0]        Wraps;
  logic              Error;
  logic [1:0]        ErrCode;

  modport master (
    output En, Gray, Overflow, Clear,
    input  Bin, Wraps, Error, ErrCode
  );

  modport slave (
    input  En, Gray, Overflow, Clear,
    output Bin, Wraps, Error, ErrCode
  );

endinterface

// File: rtl/gray2bin.sv
// Combinational gray-to-binary conversion: each binary bit is the XOR of
// all gray bits at and above it.
module gray2bin
  import gray_pkg::*;
#(
  parameter int W = GRAY_W
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_checker.sv
// Checker for an upstream 3-bit gray counter: flags illegal steps and
// Overflow mismatches, counts legal wraps, and reports the binary value.
module gray_checker
  import gray_pkg::*;
(
  input logic           Clk,
  input logic           Reset,
  gray_checker_if.slave bus
);

  // state   | meaning
  // S_IDLE  | first edge after reset: capture only, no check
  // S_TRACK | checking every edge, legal wraps counted
  // S_ERR   | checking continues, error latched, wraps frozen

  logic [1:0]        state;
  logic [GRAY_W-1:0] prev_gray;
  logic              prev_en;
  logic [GRAY_W-1:0] bin_q;
  logic [GRAY_W-1:0] bin_now;
  logic [GRAY_W-1:0] expected;
  logic              step_err;
  logic              ovf_err;
  logic              wrap_hit;
  logic [7:0]        wraps_q;
  logic              error_q;
  logic [1:0]        code_q;

  gray2bin #(.W(GRAY_W)) u_gray2bin (
    .gray (bus.Gray),
    .bin  (bin_now)
  );

  // bin_q always holds gray2bin(prev_gray), so it serves as the successor base.
  always_comb begin
    expected = prev_en ? bin2gray(bin_q + GRAY_W'(1)) : prev_gray;
    step_err = (bus.Gray != expected);
    ovf_err  = (bus.Overflow != (bus.Gray == G7));
    wrap_hit = prev_en && (prev_gray == G7) && (bus.Gray == G0) && !step_err;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      prev_gray <= G0;
      prev_en   <= 1'b0;
      bin_q     <= '0;
      wraps_q   <= 8'd0;
      error_q   <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      prev_gray <= bus.Gray;
      prev_en   <= bus.En;
      bin_q     <= bin_now;
      if (bus.Clear) begin
        wraps_q <= 8'd0;
        error_q <= 1'b0;
        code_q  <= ERR_NONE;
        state   <= S_TRACK;
      end else if (state == S_IDLE) begin
        state <= S_TRACK;
      end else if (state == S_TRACK || state == S_ERR) begin
        if (state == S_TRACK && wrap_hit && wraps_q != 8'hFF) begin
          wraps_q <= wraps_q + 8'd1;
        end
        if (step_err || ovf_err) begin
          code_q  <= code_q | (step_err ? ERR_STEP : ERR_NONE)
                            | (ovf_err  ? ERR_OVF  : ERR_NONE);
          error_q <= 1'b1;
          state   <= S_ERR;
        end
      end else begin
        state <= S_IDLE;
      end
    end
  end

  assign bus.Bin     = bin_q;
  assign bus.Wraps   = wraps_q;
  assign bus.Error   = error_q;
  assign bus.ErrCode = code_q;

endmodule

// File: tb/tb_gray_checker.sv
// Randomized and directed bench for gray_checker against a sequence-table
// reference model of the upstream counter and the checking rules.
module tb_gray_checker;

  localparam logic [2:0] SEQ [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                     3'b110, 3'b111, 3'b101, 3'b100};

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  gray_checker_if bus();

  gray_checker dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  int cnt   = 0;

  bit         m_started;
  bit         m_in_err;
  bit         m_err;
  logic [1:0] m_code;
  int         m_wraps;
  logic [2:0] m_prev_g;
  bit         m_prev_en;
  int         m_bin;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic int idx_of(input logic [2:0] g);
    for (int i = 0; i < 8; i++) if (SEQ[i] == g) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_started = 0; m_in_err = 0; m_err = 0; m_code = 2'b00;
    m_wraps = 0; m_prev_g = 3'b000; m_prev_en = 0; m_bin = 0;
  endtask

  task automatic model_edge(input logic en, input logic [2:0] g, input logic ovf, input logic clr);
    logic [2:0] exp_g;
    bit se, oe;
    if (clr) begin
      m_err = 0; m_code = 2'b00; m_wraps = 0; m_in_err = 0; m_started = 1;
    end else if (!m_started) begin
      m_started = 1;
    end else begin
      exp_g = m_prev_en ? SEQ[(idx_of(m_prev_g) + 1) % 8] : m_prev_g;
      se = (g != exp_g);
      oe = (ovf != (g == 3'b100));
      if (!m_in_err && !se && m_prev_en && m_prev_g == 3'b100 && g == 3'b000 && m_wraps < 255)
        m_wraps++;
      if (se || oe) begin
        m_code = m_code | {oe, se};
        m_err = 1;
        m_in_err = 1;
      end
    end
    m_prev_g = g;
    m_prev_en = en;
    m_bin = idx_of(g);
  endtask

  task automatic step(input logic en, input logic [2:0] g, input logic ovf,
                      input logic clr, input string tag);
    @(negedge Clk);
    bus.En = en; bus.Gray = g; bus.Overflow = ovf; bus.Clear = clr;
    @(posedge Clk);
    model_edge(en, g, ovf, clr);
    #1;
    chk({tag, ".bin"},  32'(bus.Bin),     32'(m_bin));
    chk({tag, ".wrap"}, 32'(bus.Wraps),   32'(m_wraps));
    chk({tag, ".err"},  32'(bus.Error),   32'(m_err));
    chk({tag, ".code"}, 32'(bus.ErrCode), 32'(m_code));
  endtask

  // Upstream counter behaving correctly: shows SEQ[cnt], advances on En.
  task automatic good(input logic en, input logic clr, input string tag);
    step(en, SEQ[cnt], (cnt == 7), clr, tag);
    if (en) cnt = (cnt + 1) % 8;
  endtask

  // Arbitrary value forced onto the bus; upstream resyncs to it.
  task automatic raw(input logic en, input logic [2:0] g, input logic ovf,
                     input logic clr, input string tag);
    step(en, g, ovf, clr, tag);
    cnt = (idx_of(g) + (en ? 1 : 0)) % 8;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.En = 0; bus.Gray = 3'b000; bus.Overflow = 0; bus.Clear = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.bin",  32'(bus.Bin), 0);
    chk("rst.wrap", 32'(bus.Wraps), 0);
    chk("rst.err",  32'(bus.Error), 0);
    chk("rst.code", 32'(bus.ErrCode), 0);
    @(posedge Clk);
    #1 Reset = 0;

    // Sixteen enabled cycles, then one more edge to observe the second wrap.
    for (int i = 0; i < 16; i++) good(1, 0, "run16");
    good(0, 0, "run16");
    chk("run16.wraps2", 32'(bus.Wraps), 2);
    chk("run16.noerr",  32'(bus.Error), 0);

    for (int i = 0; i < 300; i++)
      good(1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), "rnd_ok");

    // Illegal step 001 -> 010.
    good(1, 1, "stp.clr");
    while (cnt != 1) good(1, 0, "stp.pre");
    good(1, 0, "stp.001");
    raw(1, 3'b010, 0, 0, "stp.bad");
    chk("stp.err",  32'(bus.Error), 1);
    chk("stp.code", 32'(bus.ErrCode), 32'h1);
    for (int i = 0; i < 10; i++) good(1, 0, "stp.post");

    // Overflow mismatch, then an additional illegal step.
    good(1, 1, "ovf.clr");
    while (cnt != 7) good(1, 0, "ovf.pre");
    raw(1, 3'b100, 0, 0, "ovf.bad");
    chk("ovf.code", 32'(bus.ErrCode), 32'h2);
    for (int i = 0; i < 3; i++) good(1, 0, "ovf.mid");
    raw(1, SEQ[(cnt + 3) % 8], (SEQ[(cnt + 3) % 8] == 3'b100), 0, "ovf.step");
    chk("ovf.both", 32'(bus.ErrCode), 32'h3);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] g;
      logic ovf, en, clr;
      en = 1'($urandom_range(0, 1));
      g = SEQ[cnt];
      if ($urandom_range(0, 7) == 0) g = 3'($urandom_range(0, 7));
      ovf = (g == 3'b100);
      if ($urandom_range(0, 9) == 0) ovf = !ovf;
      clr = ($urandom_range(0, 15) == 0);
      raw(en, g, ovf, clr, "rnd_flt");
    end

    // Saturation: well over 255 wraps.
    good(1, 1, "sat.clr");
    for (int i = 0; i < 260 * 8; i++) good(1, 0, "sat");
    chk("sat.255", 32'(bus.Wraps), 255);

    // Clear wins over an error detected at the same edge.
    raw(1, SEQ[(cnt + 2) % 8], 0, 0, "clr.pre");
    raw(1, SEQ[(cnt + 2) % 8], 0, 1, "clr.same");
    chk("clr.err",  32'(bus.Error), 0);
    chk("clr.code", 32'(bus.ErrCode), 0);
    chk("clr.wrap", 32'(bus.Wraps), 0);
    for (int i = 0; i < 12; i++) good(1, 0, "clr.post");

    // Reset mid-count while the counter shows 110.
    raw(1, SEQ[(cnt + 5) % 8], 1, 0, "mrst.dirty");
    while (cnt != 4) good(1, 0, "mrst.pre");
    @(negedge Clk);
    bus.En = 0; bus.Gray = SEQ[4]; bus.Overflow = 0; bus.Clear = 0;
    #2 Reset = 1;
    #1;
    chk("mrst.bin",  32'(bus.Bin), 0);
    chk("mrst.wrap", 32'(bus.Wraps), 0);
    chk("mrst.err",  32'(bus.Error), 0);
    chk("mrst.code", 32'(bus.ErrCode), 0);
    model_reset();
    @(posedge Clk);
    #1 Reset = 0;
    good(0, 0, "mrst.cap");
    chk("mrst.bin4", 32'(bus.Bin), 4);
    chk("mrst.ok",   32'(bus.Error), 0);
    for (int i = 0; i < 20; i++) good(1, 0, "mrst.post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
